can_rx: RTL and testbench

- Receives extended-format CAN frames from the bus pin.
- Handles bit timing, hard and soft sync, de-stuffing and CRC-15 checking, and drives the ACK slot.
- Decodes the team's LLC identifier layout into parallel fields and presents each frame with a one-cycle valid strobe.
- It is the receive counterpart of the team's CAN transmitter and sits between the bus transceiver RX pin and the LLC command/data logic.

---
 rtl/can_pkg.sv | 27 ++
 rtl/can_bit_timing.sv | 48 ++++
 rtl/can_rx.sv | 176 +++++++++++++++++
 tb/tb_can_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive path.
package can_pkg;

  typedef enum logic [3:0] {
    RX_INTEGRATE, RX_IDLE, RX_ID_A, RX_SRR, RX_IDE, RX_ID_B, RX_RTR, RX_RES,
    RX_DLC, RX_DATA, RX_CRC, RX_CRC_DELIM, RX_ACK_SLOT, RX_ACK_DELIM, RX_EOF,
    RX_ERROR
  } rx_state_e;

  localparam logic [14:0] CRC_POLY  = 15'h4599;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned SIGN_W    = 2;
  localparam int unsigned ATTR_W    = 2;
  localparam int unsigned EXP_W     = 4;
  localparam int unsigned CDS_W     = 8;
  localparam int unsigned DLC_W     = 4;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned EOF_LEN   = 7;
  localparam int unsigned INTEG_CNT = 11;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic [14:0] sh;
    sh = {crc[13:0], 1'b0};
    return (b ^ crc[14]) ? (sh ^ CRC_POLY) : sh;
  endfunction

endpackage

// File: rtl/can_bit_timing.sv
// Bus input synchronizer, recessive-to-dominant edge resync and bit phase ticks.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 50,
  parameter int unsigned SAMPLE_PT    = 35
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic sample_o,
  output logic bit_start_o
);

  localparam int unsigned PW = $clog2(CLKS_PER_BIT);

  logic          sync1_q, sync2_q, prev_q;
  logic [PW-1:0] phase_q, phase_d;
  logic          fall_edge;

  assign fall_edge = prev_q & ~sync2_q;

  always_comb begin
    phase_d = phase_q + PW'(1);
    if (fall_edge || (phase_q == PW'(CLKS_PER_BIT - 1))) phase_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      phase_q <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      phase_q <= phase_d;
    end
  end

  // An edge in the same cycle as a tick suppresses the tick.
  assign rx_s_o      = sync2_q;
  assign sample_o    = !fall_edge && (phase_q == PW'(SAMPLE_PT));
  assign bit_start_o = !fall_edge && (phase_q == '0);

endmodule

// File: rtl/can_rx.sv
// Extended-frame CAN receiver: de-stuffing, CRC-15 check, ACK drive and LLC field decode.
module can_rx
  import can_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 50,
  parameter int unsigned SAMPLE_PT    = 35
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              ack_o,
  output logic              rx_busy,
  output logic              rx_valid_o,
  output logic              msg_type_o,
  output logic [ADDR_W-1:0] address_sender_o,
  output logic [ADDR_W-1:0] address_recipient_o,
  output logic [SIGN_W-1:0] sign_o,
  output logic [ATTR_W-1:0] attribute_o,
  output logic [EXP_W-1:0]  expand_count_o,
  output logic [CDS_W-1:0]  cmd_data_sign_o,
  output logic              rtr_o,
  output logic [DLC_W-1:0]  data_l_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic              err_stuff_o,
  output logic              err_crc_o,
  output logic              err_form_o
);

  logic rx_s, sample, bit_start;

  can_bit_timing #(.CLKS_PER_BIT(CLKS_PER_BIT), .SAMPLE_PT(SAMPLE_PT)) u_bt (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i),
    .rx_s_o(rx_s), .sample_o(sample), .bit_start_o(bit_start)
  );

  rx_state_e          state_q;
  logic [5:0]         bit_cnt_q;
  logic [2:0]         run_q;
  logic               last_q;
  logic [28:0]        id_q;
  logic               rtr_q;
  logic [DLC_W-1:0]   dlc_q, dlc_d;
  logic [5:0]         data_last_q, data_last_d;
  logic [DATA_W-1:0]  data_q;
  logic [14:0]        crc_q, crc_d, crc_rx_q;
  logic               ack_arm_q;
  logic               crc_feed, stuffed, destuff;

  assign crc_feed = state_q inside {RX_ID_A, RX_SRR, RX_IDE, RX_ID_B, RX_RTR, RX_RES,
                                    RX_DLC, RX_DATA};
  assign stuffed  = crc_feed || (state_q == RX_CRC);
  // A stuff bit may still follow the last CRC bit, so CRC_DELIM checks the run too.
  assign destuff  = (run_q == 3'd5) && (stuffed || (state_q == RX_CRC_DELIM));
  assign crc_d    = crc15_step(crc_q, rx_s);
  assign dlc_d    = {dlc_q[2:0], rx_s};
  assign data_last_d = {(dlc_d[3] ? 3'd7 : dlc_d[2:0] - 3'd1), 3'b111};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RX_INTEGRATE;  bit_cnt_q <= '0;  run_q <= '0;  last_q <= 1'b1;
      id_q <= '0;  rtr_q <= 1'b0;  dlc_q <= '0;  data_last_q <= '0;  data_q <= '0;
      crc_q <= '0;  crc_rx_q <= '0;  ack_arm_q <= 1'b0;
      ack_o <= 1'b1;  rx_busy <= 1'b0;  rx_valid_o <= 1'b0;
      msg_type_o <= 1'b0;  address_sender_o <= '0;  address_recipient_o <= '0;
      sign_o <= '0;  attribute_o <= '0;  expand_count_o <= '0;  cmd_data_sign_o <= '0;
      rtr_o <= 1'b0;  data_l_o <= '0;  data_b_o <= '0;
      err_stuff_o <= 1'b0;  err_crc_o <= 1'b0;  err_form_o <= 1'b0;
    end else begin
      rx_valid_o  <= 1'b0;
      err_stuff_o <= 1'b0;
      err_crc_o   <= 1'b0;
      err_form_o  <= 1'b0;
      if (bit_start) begin
        ack_o     <= ~ack_arm_q;
        ack_arm_q <= 1'b0;
      end
      if (sample) begin
        if (destuff) begin
          if (rx_s == last_q) begin
            err_stuff_o <= 1'b1;  state_q <= RX_ERROR;  bit_cnt_q <= '0;
          end else begin
            run_q  <= 3'd1;
            last_q <= rx_s;
          end
        end else begin
          if (stuffed) begin
            run_q  <= (rx_s == last_q) ? run_q + 3'd1 : 3'd1;
            last_q <= rx_s;
          end
          if (crc_feed) crc_q <= crc_d;
          case (state_q)
            RX_INTEGRATE, RX_ERROR: begin
              if (!rx_s) bit_cnt_q <= '0;
              else if (bit_cnt_q == 6'(INTEG_CNT - 1)) begin
                state_q <= RX_IDLE;  bit_cnt_q <= '0;  rx_busy <= 1'b0;
              end else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            RX_IDLE: if (!rx_s) begin
              state_q <= RX_ID_A;  bit_cnt_q <= '0;  rx_busy <= 1'b1;
              run_q <= 3'd1;  last_q <= 1'b0;  crc_q <= '0;  data_q <= '0;
            end
            RX_ID_A: begin
              id_q <= {id_q[27:0], rx_s};
              if (bit_cnt_q == 6'd10) begin state_q <= RX_SRR;  bit_cnt_q <= '0; end
              else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            RX_SRR, RX_IDE: begin
              if (!rx_s) begin err_form_o <= 1'b1;  state_q <= RX_ERROR; end
              else state_q <= (state_q == RX_SRR) ? RX_IDE : RX_ID_B;
            end
            RX_ID_B: begin
              id_q <= {id_q[27:0], rx_s};
              if (bit_cnt_q == 6'd17) begin state_q <= RX_RTR;  bit_cnt_q <= '0; end
              else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            RX_RTR: begin rtr_q <= rx_s;  state_q <= RX_RES; end
            RX_RES: begin
              if (bit_cnt_q == 6'd1) begin state_q <= RX_DLC;  bit_cnt_q <= '0; end
              else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            RX_DLC: begin
              dlc_q <= dlc_d;
              if (bit_cnt_q == 6'd3) begin
                data_last_q <= data_last_d;
                state_q     <= (rtr_q || dlc_d == '0) ? RX_CRC : RX_DATA;
                bit_cnt_q   <= '0;
              end else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            RX_DATA: begin
              data_q[~bit_cnt_q] <= rx_s;
              if (bit_cnt_q == data_last_q) begin state_q <= RX_CRC;  bit_cnt_q <= '0; end
              else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            RX_CRC: begin
              crc_rx_q <= {crc_rx_q[13:0], rx_s};
              if (bit_cnt_q == 6'd14) begin state_q <= RX_CRC_DELIM;  bit_cnt_q <= '0; end
              else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            RX_CRC_DELIM: begin
              if (crc_rx_q != crc_q) begin err_crc_o <= 1'b1;  state_q <= RX_ERROR; end
              else if (!rx_s) begin err_form_o <= 1'b1;  state_q <= RX_ERROR; end
              else begin ack_arm_q <= 1'b1;  state_q <= RX_ACK_SLOT; end
            end
            RX_ACK_SLOT: state_q <= RX_ACK_DELIM;
            RX_ACK_DELIM: begin
              if (!rx_s) begin err_form_o <= 1'b1;  state_q <= RX_ERROR; end
              else begin state_q <= RX_EOF;  bit_cnt_q <= '0; end
            end
            RX_EOF: begin
              if (!rx_s) begin
                err_form_o <= 1'b1;  state_q <= RX_ERROR;  bit_cnt_q <= '0;
              end else if (bit_cnt_q == 6'(EOF_LEN - 1)) begin
                msg_type_o          <= id_q[28];
                address_sender_o    <= id_q[27:22];
                address_recipient_o <= id_q[21:16];
                sign_o              <= id_q[15:14];
                attribute_o         <= id_q[13:12];
                expand_count_o      <= id_q[11:8];
                cmd_data_sign_o     <= id_q[7:0];
                rtr_o               <= rtr_q;
                data_l_o            <= dlc_q;
                data_b_o            <= data_q;
                rx_valid_o          <= 1'b1;
                rx_busy             <= 1'b0;
                state_q             <= RX_IDLE;
                bit_cnt_q           <= '0;
              end else bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            default: state_q <= RX_ERROR;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_rx.sv
// Directed bench for can_rx: frames are built, CRC'd and stuffed here and driven bit by bit.
module tb_can_rx;
  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic        ack_o, rx_busy, rx_valid_o, msg_type_o, rtr_o;
  logic [5:0]  address_sender_o, address_recipient_o;
  logic [1:0]  sign_o, attribute_o;
  logic [3:0]  expand_count_o, data_l_o;
  logic [7:0]  cmd_data_sign_o;
  logic [63:0] data_b_o;
  logic        err_stuff_o, err_crc_o, err_form_o;

  can_rx #(.CLKS_PER_BIT(50), .SAMPLE_PT(35)) dut (
    .clk_i(clk), .rst_i(rst_n), .rx_i(rx), .ack_o(ack_o), .rx_busy(rx_busy),
    .rx_valid_o(rx_valid_o), .msg_type_o(msg_type_o), .address_sender_o(address_sender_o),
    .address_recipient_o(address_recipient_o), .sign_o(sign_o), .attribute_o(attribute_o),
    .expand_count_o(expand_count_o), .cmd_data_sign_o(cmd_data_sign_o), .rtr_o(rtr_o),
    .data_l_o(data_l_o), .data_b_o(data_b_o), .err_stuff_o(err_stuff_o),
    .err_crc_o(err_crc_o), .err_form_o(err_form_o)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int n_valid = 0, n_stuff = 0, n_crc = 0, n_form = 0, n_ack = 0;
  int b_valid, b_stuff, b_crc, b_form, b_ack;

  always @(negedge clk) begin
    if (rx_valid_o)  n_valid++;
    if (err_stuff_o) n_stuff++;
    if (err_crc_o)   n_crc++;
    if (err_form_o)  n_form++;
    if (!ack_o)      n_ack++;
  end

  logic rawb [0:255];
  logic fb   [0:255];
  int   rlen, flen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid; b_stuff = n_stuff; b_crc = n_crc; b_form = n_form; b_ack = n_ack;
  endtask

  task automatic check_events(input string t, input int v, input int s, input int c, input int f);
    check({t, "_valid"}, 64'(n_valid - b_valid), 64'(v));
    check({t, "_stuff"}, 64'(n_stuff - b_stuff), 64'(s));
    check({t, "_crc"},   64'(n_crc - b_crc),     64'(c));
    check({t, "_form"},  64'(n_form - b_form),   64'(f));
    check({t, "_busy"},  64'(rx_busy),           64'(1'b0));
  endtask

  task automatic check_fields(input string t, input logic mt, input logic [5:0] snd,
      input logic [5:0] rcp, input logic [1:0] sg, input logic [1:0] at, input logic [3:0] ex,
      input logic [7:0] cds, input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
    check({t, "_type"}, 64'(msg_type_o),          64'(mt));
    check({t, "_snd"},  64'(address_sender_o),    64'(snd));
    check({t, "_rcp"},  64'(address_recipient_o), 64'(rcp));
    check({t, "_sign"}, 64'(sign_o),              64'(sg));
    check({t, "_attr"}, 64'(attribute_o),         64'(at));
    check({t, "_exp"},  64'(expand_count_o),      64'(ex));
    check({t, "_cds"},  64'(cmd_data_sign_o),     64'(cds));
    check({t, "_rtr"},  64'(rtr_o),               64'(rtr));
    check({t, "_dlc"},  64'(data_l_o),            64'(dlc));
    check({t, "_data"}, data_b_o,                 data);
  endtask

  task automatic check_reset(input string t);
    check({t, "_ack"},   64'(ack_o),      64'(1'b1));
    check({t, "_busy"},  64'(rx_busy),    64'(1'b0));
    check({t, "_valid"}, 64'(rx_valid_o), 64'(1'b0));
    check({t, "_errs"},  64'({err_stuff_o, err_crc_o, err_form_o}), 64'(3'b000));
    check_fields(t, 1'b0, 6'h0, 6'h0, 2'h0, 2'h0, 4'h0, 8'h0, 1'b0, 4'h0, 64'h0);
  endtask

  task automatic put(input logic b);
    rawb[rlen] = b;
    rlen++;
  endtask

  task automatic put_n(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) put(v[i]);
  endtask

  task automatic build(input logic mt, input logic [5:0] snd, input logic [5:0] rcp,
      input logic [1:0] sg, input logic [1:0] at, input logic [3:0] ex, input logic [7:0] cds,
      input logic rtr, input logic [3:0] dlc, input logic [63:0] data, input logic ide,
      input logic flip);
    logic [14:0] crc;
    logic        nx, last;
    int          nb, run;
    rlen = 0;
    put(1'b0); put(mt); put_n(64'(snd), 6); put_n(64'(rcp[5:2]), 4);
    put(1'b1); put(ide);
    put_n(64'(rcp[1:0]), 2); put_n(64'(sg), 2); put_n(64'(at), 2); put_n(64'(ex), 4);
    put_n(64'(cds), 8); put(rtr); put(1'b0); put(1'b0); put_n(64'(dlc), 4);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
    for (int i = 0; i < nb; i++) put(data[63 - i]);
    crc = '0;
    for (int i = 0; i < rlen; i++) begin
      nx  = rawb[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nx) crc = crc ^ 15'h4599;
    end
    if (flip) crc[3] = ~crc[3];
    put_n(64'(crc), 15);
    flen = 0; run = 0; last = 1'b0;
    for (int i = 0; i < rlen; i++) begin
      fb[flen] = rawb[i]; flen++;
      if (i > 0 && rawb[i] == last) run++; else run = 1;
      last = rawb[i];
      if (run == 5) begin
        fb[flen] = ~last; flen++;
        last = ~last; run = 1;
      end
    end
    for (int i = 0; i < 10; i++) begin fb[flen] = 1'b1; flen++; end
  endtask

  // mode 0: 50 clocks/bit, 1: 52 clocks/bit, 2: alternating 48/52
  task automatic send(input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      int len;
      len = (mode == 0) ? 50 : (mode == 1) ? 52 : ((i % 2) != 0 ? 52 : 48);
      rx = fb[i];
      repeat (len) @(negedge clk);
    end
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * 50) @(negedge clk);
  endtask

  task automatic build_nominal(input logic ide, input logic flip);
    build(1'b0, 6'b000101, 6'b100010, 2'b10, 2'b10, 4'b1011, 8'hF5, 1'b0, 4'b1001,
          64'h3132333435363738, ide, flip);
  endtask

  task automatic build_b();
    build(1'b0, 6'b000000, 6'b111000, 2'b01, 2'b11, 4'b0101, 8'h3C, 1'b0, 4'd2,
          64'hA55A_FFFF_FFFF_FFFF, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    idle(12);

    // nominal frame
    snap(); build_nominal(1'b1, 1'b0); send(flen, 0); idle(3);
    check_events("nom", 1, 0, 0, 0);
    check("nom_ack_cycles", 64'(n_ack - b_ack), 64'd50);
    check_fields("nom", 1'b0, 6'b000101, 6'b100010, 2'b10, 2'b10, 4'b1011, 8'hF5, 1'b0,
                 4'd9, 64'h3132333435363738);

    // six dominant bits in ID_A: replace the first stuff bit
    snap(); build_b(); fb[5] = 1'b0; send(10, 0); idle(12);
    check_events("stuff", 0, 1, 0, 0);
    check("stuff_keep_data", data_b_o, 64'h3132333435363738);
    snap(); build_b(); send(flen, 0); idle(3);
    check_events("fb", 1, 0, 0, 0);
    check_fields("fb", 1'b0, 6'b000000, 6'b111000, 2'b01, 2'b11, 4'b0101, 8'h3C, 1'b0,
                 4'd2, 64'hA55A_0000_0000_0000);

    // corrupted CRC
    snap(); build_nominal(1'b1, 1'b1); send(flen, 0); idle(12);
    check_events("crc", 0, 0, 1, 0);
    check("crc_ack_cycles", 64'(n_ack - b_ack), 64'd0);
    check("crc_keep_snd", 64'(address_sender_o), 64'(6'b000000));
    check("crc_keep_data", data_b_o, 64'hA55A_0000_0000_0000);

    // remote frame
    snap();
    build(1'b1, 6'b110011, 6'b001100, 2'b11, 2'b01, 4'b1110, 8'h0A, 1'b1, 4'd4,
          64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    send(flen, 0); idle(3);
    check_events("rtr", 1, 0, 0, 0);
    check_fields("rtr", 1'b1, 6'b110011, 6'b001100, 2'b11, 2'b01, 4'b1110, 8'h0A, 1'b1,
                 4'd4, 64'h0);

    // slow transmitter then jittered transmitter
    snap(); build_nominal(1'b1, 1'b0); send(flen, 1); idle(3);
    check_events("slow", 1, 0, 0, 0);
    check_fields("slow", 1'b0, 6'b000101, 6'b100010, 2'b10, 2'b10, 4'b1011, 8'hF5, 1'b0,
                 4'd9, 64'h3132333435363738);
    snap(); build_nominal(1'b1, 1'b0); send(flen, 2); idle(3);
    check_events("jit", 1, 0, 0, 0);
    check("jit_data", data_b_o, 64'h3132333435363738);

    // IDE = 0
    snap(); build_nominal(1'b0, 1'b0); send(flen, 0); idle(12);
    check_events("ide", 0, 0, 0, 1);

    // reset in the data field, then integration
    build_nominal(1'b1, 1'b0); send(60, 0);
    check("mid_busy", 64'(rx_busy), 64'(1'b1));
    rst_n = 1'b0; rx = 1'b1;
    #1;
    check_reset("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap();
    idle(5); rx = 1'b0; repeat (50) @(negedge clk); idle(3);
    check_events("integ", 0, 0, 0, 0);
    idle(12);
    snap(); build_b(); send(flen, 0); idle(3);
    check_events("post", 1, 0, 0, 0);
    check_fields("post", 1'b0, 6'b000000, 6'b111000, 2'b01, 2'b11, 4'b0101, 8'h3C, 1'b0,
                 4'd2, 64'hA55A_0000_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
